// File: rtl/pmp_arb_pkg.sv
// Shared types and constants for the PMP check arbiter: FSM states, requester indices,
// access masks and the pmpcfg byte layout.
package pmp_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LSU   = 1'b1;

    localparam logic [2:0] ACC_R = 3'b001;
    localparam logic [2:0] ACC_W = 3'b010;
    localparam logic [2:0] ACC_X = 3'b100;

    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        AOff   = 2'd0,
        ATor   = 2'd1,
        ANa4   = 2'd2,
        ANapot = 2'd3
    } pmp_mode_e;

    typedef struct packed {
        logic      locked;
        logic [1:0] rsvd;
        pmp_mode_e mode;
        logic [2:0] xwr;
    } pmp_cfg_t;

endpackage

// File: rtl/pmp_check_arbiter_pmp.sv
// Combinational PMP checker: the lowest-indexed matching entry decides, and an
// unmatched access is allowed only in M-mode.
module pmp_check_arbiter_pmp
    import pmp_arb_pkg::*;
#(
    parameter int unsigned PLEN       = 34,
    parameter int unsigned PMP_LEN    = 32,
    parameter int unsigned NR_ENTRIES = 4
) (
    input  logic [PLEN-1:0]       addr_i,
    input  logic [2:0]            access_i,
    input  logic [1:0]            priv_i,
    input  logic [16*PMP_LEN-1:0] conf_addr_i,
    input  logic [127:0]          conf_i,
    output logic                  allow_o
);

    // pmpaddr holds address bits [PLEN-1:2]; compare in a common width.
    localparam int unsigned CW = (PLEN - 2 > PMP_LEN) ? PLEN - 2 : PMP_LEN;

    logic [CW-1:0]         addr_word;
    logic [NR_ENTRIES-1:0] match;
    logic [NR_ENTRIES-1:0] perm_ok;
    logic [NR_ENTRIES-1:0] enforce;
    logic                  unused_bits;

    assign addr_word   = CW'(addr_i[PLEN-1:2]);
    assign unused_bits = ^{conf_i, conf_addr_i, addr_i[1:0]};

    for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_entry
        pmp_cfg_t      cfg;
        logic [CW-1:0] cur;
        logic [CW-1:0] prev;
        logic [CW-1:0] napot_mask;
        logic          unused_rsvd;

        assign cfg = pmp_cfg_t'(conf_i[8*i +: 8]);
        assign cur = CW'(conf_addr_i[i*PMP_LEN +: PMP_LEN]);

        if (i == 0) begin : g_first
            assign prev = '0;
        end else begin : g_rest
            assign prev = CW'(conf_addr_i[(i-1)*PMP_LEN +: PMP_LEN]);
        end

        // Trailing ones plus the first zero mark the NAPOT don't-care bits.
        assign napot_mask  = cur ^ (cur + CW'(1));
        assign unused_rsvd = ^cfg.rsvd;

        assign match[i] = (cfg.mode == ATor)   ? ((addr_word >= prev) && (addr_word < cur)) :
                          (cfg.mode == ANa4)   ? (addr_word == cur) :
                          (cfg.mode == ANapot) ? (((addr_word ^ cur) & ~napot_mask) == '0) :
                                                 1'b0;
        assign perm_ok[i] = (access_i & cfg.xwr) == access_i;
        assign enforce[i] = (priv_i != PRIV_M) || cfg.locked;
    end

    always_comb begin
        allow_o = (priv_i == PRIV_M);
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                allow_o = enforce[i] ? perm_ok[i] : 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmp_check_arbiter.sv
// Round-robin arbiter between fetch and LSU that runs one PMP check at a time
// through an IDLE -> BUSY -> RESP sequence.
module pmp_check_arbiter
    import pmp_arb_pkg::*;
#(
    parameter int unsigned PLEN       = 34,
    parameter int unsigned PMP_LEN    = 32,
    parameter int unsigned NR_ENTRIES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [2*PLEN-1:0]     req_addr_i,
    input  logic [5:0]            req_access_i,
    input  logic [3:0]            req_priv_i,
    output logic                  resp_valid_o,
    output logic                  resp_id_o,
    output logic                  resp_allow_o,
    input  logic                  resp_ready_i,
    input  logic [16*PMP_LEN-1:0] conf_addr_i,
    input  logic [127:0]          conf_i,
    input  logic                  cfg_stall_i,
    input  logic                  flush_i,
    output logic                  idle_o
);

    arb_state_e      state_q;
    logic            last_grant_q;
    logic [PLEN-1:0] addr_q;
    logic [2:0]      access_q;
    logic [1:0]      priv_q;
    logic            id_q;
    logic            allow_q;

    logic            grant_idx;
    logic [1:0]      ready;
    logic [PLEN-1:0] sel_addr;
    logic [2:0]      sel_access;
    logic [1:0]      sel_priv;
    logic            pmp_allow;

    always_comb begin
        if (&req_valid_i) begin
            grant_idx = ~last_grant_q;
        end else begin
            grant_idx = req_valid_i[REQ_LSU] ? REQ_LSU : REQ_FETCH;
        end
        ready = 2'b00;
        // Reset is folded in so no grant is visible while rst_i is held.
        if ((state_q == StIdle) && !cfg_stall_i && !flush_i && !rst_i && (|req_valid_i)) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign sel_addr   = grant_idx ? req_addr_i[2*PLEN-1:PLEN] : req_addr_i[PLEN-1:0];
    assign sel_access = grant_idx ? req_access_i[5:3] : req_access_i[2:0];
    assign sel_priv   = grant_idx ? req_priv_i[3:2] : req_priv_i[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= REQ_LSU;
            addr_q       <= '0;
            access_q     <= '0;
            priv_q       <= '0;
            id_q         <= 1'b0;
            allow_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|ready) begin
                        addr_q       <= sel_addr;
                        access_q     <= sel_access;
                        priv_q       <= sel_priv;
                        id_q         <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= StBusy;
                    end
                end
                StBusy: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else begin
                        allow_q <= pmp_allow;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (flush_i || resp_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    pmp_check_arbiter_pmp #(
        .PLEN      (PLEN),
        .PMP_LEN   (PMP_LEN),
        .NR_ENTRIES(NR_ENTRIES)
    ) pmp (
        .addr_i     (addr_q),
        .access_i   (access_q),
        .priv_i     (priv_q),
        .conf_addr_i(conf_addr_i),
        .conf_i     (conf_i),
        .allow_o    (pmp_allow)
    );

    assign req_ready_o  = ready;
    assign resp_valid_o = (state_q == StResp);
    assign resp_id_o    = id_q;
    assign resp_allow_o = allow_q;
    assign idle_o       = (state_q == StIdle);

endmodule

// File: doc/pmp_check_arbiter.md
PMP_CHECK_ARBITER -- requirements
Module: pmp_check_arbiter

Interface
REQ-001 SHALL have parameter PLEN, default 34: physical address width.
REQ-002 SHALL have parameter PMP_LEN, default 32: pmpaddr width.
REQ-003 SHALL have parameter NR_ENTRIES, default 4: active PMP entries.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid_i, input, 2: request valid; index 0 fetch, 1 LSU.
REQ-007 SHALL have port req_ready_o, output, 2: request accepted when valid & ready.
REQ-008 SHALL have port req_addr_i, input, 2*PLEN: per-requester address.
REQ-009 SHALL have port req_access_i, input, 2*3: per-requester access type {X,W,R}.
REQ-010 SHALL have port req_priv_i, input, 2*2: per-requester privilege (11 = M).
REQ-011 SHALL have port resp_valid_o, output, 1: result valid.
REQ-012 SHALL have port resp_id_o, output, 1: requester index of the result.
REQ-013 SHALL have port resp_allow_o, output, 1: access permitted.
REQ-014 SHALL have port resp_ready_i, input, 1: consumer takes the result.
REQ-015 SHALL have port conf_addr_i, input, 16*PMP_LEN: pmpaddr CSRs.
REQ-016 SHALL have port conf_i, input, 128: pmpcfg bytes {L,-,-,A[1:0],X,W,R}.
REQ-017 SHALL have port cfg_stall_i, input, 1: CSR writer blocks new grants.
REQ-018 SHALL have port flush_i, input, 1: abort any in-flight check.
REQ-019 SHALL have port idle_o, output, 1: no check in flight.

Function
REQ-020 SHALL use FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-021 SHALL assert req_ready_o[r] only in IDLE, with cfg_stall_i=0 and flush_i=0, and r the granted index; at most one bit is set.
REQ-022 SHALL grant the single valid requester; when both are valid, SHALL grant the one not granted last (round-robin); last_grant resets to 1, so fetch wins first.
REQ-023 SHALL update last_grant only on a completed handshake.
REQ-024 SHALL capture addr, access, priv and id into registers on handshake and go to BUSY.
REQ-025 In BUSY, SHALL evaluate the PMP on the captured request and live conf, register the allow result, and go to RESP.
REQ-026 SHALL hold resp_valid_o=1 in RESP, with id and allow stable until resp_ready_i=1; the cycle after that, the FSM is in IDLE.
REQ-027 Latency: handshake in cycle t gives resp_valid_o in cycle t+2; minimum request spacing is 3 cycles.
REQ-028 SHALL follow PMP rules: the lowest-indexed match decides; the entry applies if priv != M or L=1; allow iff (access & cfg.XWR) == access; no match gives allow = (priv == M).
REQ-029 When flush_i=1 in BUSY or RESP, SHALL go to IDLE the next cycle with resp_valid_o=0 and the result discarded; flush_i=1 in IDLE SHALL block grants.
REQ-030 A flush in the same cycle as a RESP handshake SHALL count as a completed response.
REQ-031 SHALL assert idle_o iff state == IDLE; the CSR writer SHALL change conf only while cfg_stall_i=1 and idle_o=1.
REQ-032 SHALL let cfg_stall_i=1 during BUSY or RESP finish the in-flight check normally.

Reset
REQ-033 On rst_i=1, SHALL immediately set state=IDLE, resp_valid_o=0, resp_allow_o=0, resp_id_o=0, last_grant=1, captured regs=0, idle_o=1 and req_ready_o=0.
REQ-034 Reset mid-check SHALL drop the check, emitting no response.

Structure
REQ-035 SHALL place the FSM state enum, requester index constants (REQ_FETCH=0, REQ_LSU=1) and access-type masks in shared package pmp_arb_pkg.
REQ-036 SHALL instantiate exactly one pmp checker sub-module, named pmp, fed from the captured registers.

Verification
REQ-037 Entry0 TOR pmpaddr=0x400, cfg=0x09, S-mode LSU read 0x800 -> resp_allow=1, id=1, valid at t+2.
REQ-038 Same config, S-mode LSU write (access=3'b010) to 0x800 -> resp_allow=0; M-mode read of 0x2000 (no match) -> resp_allow=1.
REQ-039 Both requesters valid for 4 checks -> grant order fetch, LSU, fetch, LSU.
REQ-040 resp_ready_i held 0 for 5 cycles in RESP -> resp_valid/id/allow stable, req_ready_o=0 throughout.
REQ-041 flush_i pulsed in BUSY -> no resp_valid_o, idle_o=1 the next cycle; rst_i pulsed in RESP -> resp_valid_o=0 immediately.
REQ-042 cfg_stall_i=1 with both valid -> req_ready_o=00; deassert -> fetch granted the next cycle.
